// File: rtl/setup_result_collector.sv
// setup_result_collector: receive side of the DFF setup-time sweep.
// For each (clk slope, d slope) point it scans trials from MAX_OFF down to 0.
// It keeps the smallest passing offset seen before the first failure.
// Each point's result is streamed over valid/ready and stored in a table.
// The table can be read back through a registered random-access port.
// Optional build macro: SETUP_MONOTONIC_CHECK_EN. When defined, it adds the
// nonmono output and a per-point nonmono bit in each table entry.
module setup_result_collector #(
  parameter int OFFW    = 7,
  parameter int MAX_OFF = 100,
  parameter int NB_CK   = 3,
  parameter int NB_D    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            trial_valid,
  input  logic [OFFW-1:0]                 trial_offset,
  input  logic                            trial_q,
  input  logic                            trial_exp,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [$clog2(NB_CK)-1:0]        res_ck_idx,
  output logic [$clog2(NB_D)-1:0]         res_d_idx,
  output logic [OFFW-1:0]                 res_code,
  output logic                            res_found,
`ifdef SETUP_MONOTONIC_CHECK_EN
  output logic                            nonmono,
  input  logic [$clog2(NB_CK*NB_D)-1:0]   rd_addr,
  output logic [OFFW+1:0]                 rd_data
`else
  input  logic [$clog2(NB_CK*NB_D)-1:0]   rd_addr,
  output logic [OFFW:0]                   rd_data
`endif
);

  localparam int CKW  = $clog2(NB_CK);
  localparam int DW   = $clog2(NB_D);
  localparam int NPTS = NB_CK * NB_D;
  localparam int AW   = $clog2(NPTS);
`ifdef SETUP_MONOTONIC_CHECK_EN
  localparam int EW   = OFFW + 2;
`else
  localparam int EW   = OFFW + 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_COMMIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CKW-1:0]  ck_q, ck_d;
  logic [DW-1:0]   dix_q, dix_d;
  logic [OFFW-1:0] exp_q, exp_d;
  logic            found_q, found_d;
  logic            failed_q, failed_d;
  logic [OFFW-1:0] code_q, code_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rv_q, rv_d;
  logic [CKW-1:0]  rck_q, rck_d;
  logic [DW-1:0]   rdi_q, rdi_d;
  logic [OFFW-1:0] rcode_q, rcode_d;
  logic            rfound_q, rfound_d;
  logic [EW-1:0]   rd_data_q, rd_data_d;
  logic            wr_en_s;
  logic [AW-1:0]   wr_idx_s;
  logic            pass_s;

  logic            tbl_found_q [NPTS];
  logic [OFFW-1:0] tbl_code_q  [NPTS];
`ifdef SETUP_MONOTONIC_CHECK_EN
  logic            nm_pt_q, nm_pt_d;
  logic            nonmono_q, nonmono_d;
  logic            tbl_nm_q    [NPTS];
`endif

  assign pass_s   = (trial_q == trial_exp);
  assign wr_idx_s = AW'(int'(ck_q) * NB_D + int'(dix_q));

  // Next-state, per-point evaluation and result-field logic
  always_comb begin
    state_d   = state_q;
    ck_d      = ck_q;
    dix_d     = dix_q;
    exp_d     = exp_q;
    found_d   = found_q;
    failed_d  = failed_q;
    code_d    = code_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    rv_d      = rv_q;
    rck_d     = rck_q;
    rdi_d     = rdi_q;
    rcode_d   = rcode_q;
    rfound_d  = rfound_q;
    wr_en_s   = 1'b0;
`ifdef SETUP_MONOTONIC_CHECK_EN
    nm_pt_d   = nm_pt_q;
    nonmono_d = nonmono_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // start also beats a coincident trial_valid: the trial is not looked at here
        if (start) begin
          state_d  = S_SWEEP;
          ck_d     = '0;
          dix_d    = '0;
          exp_d    = OFFW'(MAX_OFF);
          found_d  = 1'b0;
          failed_d = 1'b0;
          code_d   = '1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
`ifdef SETUP_MONOTONIC_CHECK_EN
          nm_pt_d   = 1'b0;
          nonmono_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_SWEEP: begin
        if (trial_valid) begin
          if (trial_offset != exp_q) begin
            err_d = 1'b1;
          end else begin
            if (pass_s && !failed_q) begin
              code_d  = trial_offset;
              found_d = 1'b1;
            end else if (pass_s) begin
`ifdef SETUP_MONOTONIC_CHECK_EN
              nm_pt_d   = 1'b1;
              nonmono_d = 1'b1;
`endif
            end else begin
              failed_d = 1'b1;
            end
            if (trial_offset == '0) begin
              state_d  = S_COMMIT;
              wr_en_s  = 1'b1;
              rv_d     = 1'b1;
              rck_d    = ck_q;
              rdi_d    = dix_q;
              rcode_d  = code_d;
              rfound_d = found_d;
            end else begin
              exp_d = exp_q - OFFW'(1);
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      S_COMMIT: begin
        if (rv_q && res_ready) begin
          rv_d = 1'b0;
          if (ck_q == CKW'(NB_CK - 1) && dix_q == DW'(NB_D - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = S_SWEEP;
            exp_d    = OFFW'(MAX_OFF);
            found_d  = 1'b0;
            failed_d = 1'b0;
            code_d   = '1;
`ifdef SETUP_MONOTONIC_CHECK_EN
            nm_pt_d  = 1'b0;
`endif
            if (dix_q == DW'(NB_D - 1)) begin
              dix_d = '0;
              ck_d  = ck_q + CKW'(1);
            end else begin
              dix_d = dix_q + DW'(1);
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-port data: table entry when the address is in range, zero otherwise
  always_comb begin
    rd_data_d = '0;
    if (int'(rd_addr) < NPTS) begin
`ifdef SETUP_MONOTONIC_CHECK_EN
      rd_data_d = {tbl_nm_q[rd_addr], tbl_found_q[rd_addr], tbl_code_q[rd_addr]};
`else
      rd_data_d = {tbl_found_q[rd_addr], tbl_code_q[rd_addr]};
`endif
    end else begin
      rd_data_d = '0;
    end
  end

  // Control, per-point and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ck_q      <= '0;
      dix_q     <= '0;
      exp_q     <= OFFW'(MAX_OFF);
      found_q   <= 1'b0;
      failed_q  <= 1'b0;
      code_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
      rck_q     <= '0;
      rdi_q     <= '0;
      rcode_q   <= '1;
      rfound_q  <= 1'b0;
      rd_data_q <= '0;
`ifdef SETUP_MONOTONIC_CHECK_EN
      nm_pt_q   <= 1'b0;
      nonmono_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ck_q      <= ck_d;
      dix_q     <= dix_d;
      exp_q     <= exp_d;
      found_q   <= found_d;
      failed_q  <= failed_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rv_q      <= rv_d;
      rck_q     <= rck_d;
      rdi_q     <= rdi_d;
      rcode_q   <= rcode_d;
      rfound_q  <= rfound_d;
      rd_data_q <= rd_data_d;
`ifdef SETUP_MONOTONIC_CHECK_EN
      nm_pt_q   <= nm_pt_d;
      nonmono_q <= nonmono_d;
`endif
    end
  end

  // Table found bits: cleared by reset, written when a point enters COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPTS; i++) tbl_found_q[i] <= 1'b0;
    end else if (wr_en_s) begin
      tbl_found_q[wr_idx_s] <= found_d;
    end
  end

  // Table code (and nonmono) fields: no reset, written when a point enters COMMIT
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      tbl_code_q[wr_idx_s] <= code_d;
`ifdef SETUP_MONOTONIC_CHECK_EN
      tbl_nm_q[wr_idx_s]   <= nm_pt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign res_valid  = rv_q;
  assign res_ck_idx = rck_q;
  assign res_d_idx  = rdi_q;
  assign res_code   = rcode_q;
  assign res_found  = rfound_q;
  assign rd_data    = rd_data_q;
`ifdef SETUP_MONOTONIC_CHECK_EN
  assign nonmono    = nonmono_q;
`endif

endmodule

// File: tb/tb_setup_result_collector.sv
// Self-checking bench for setup_result_collector.
// Per-point stimulus comes from a vector table.
// Expected results go into a scoreboard queue and are popped on each handshake.
module tb_setup_result_collector;
  localparam int OFFW = 7;
  localparam int NPTS = 9;
`ifdef SETUP_MONOTONIC_CHECK_EN
  localparam int RDW = OFFW + 2;
`else
  localparam int RDW = OFFW + 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, start = 1'b0, trial_valid = 1'b0;
  logic [OFFW-1:0] trial_offset = '0;
  logic            trial_q = 1'b0, trial_exp = 1'b0;
  logic            busy, done, err, res_valid, res_found;
  logic            res_ready = 1'b1;
  logic [1:0]      res_ck_idx, res_d_idx;
  logic [OFFW-1:0] res_code;
  logic [3:0]      rd_addr = '0;
  logic [RDW-1:0]  rd_data;
`ifdef SETUP_MONOTONIC_CHECK_EN
  logic            nonmono;
`endif

  setup_result_collector dut (
    .clk(clk), .rst(rst), .start(start), .trial_valid(trial_valid),
    .trial_offset(trial_offset), .trial_q(trial_q), .trial_exp(trial_exp),
    .busy(busy), .done(done), .err(err), .res_valid(res_valid),
    .res_ready(res_ready), .res_ck_idx(res_ck_idx), .res_d_idx(res_d_idx),
    .res_code(res_code), .res_found(res_found),
`ifdef SETUP_MONOTONIC_CHECK_EN
    .nonmono(nonmono),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct { int thr; int late; int code; int found; int nm; } vec_t;
  typedef struct { int ck; int d; int code; int found; } res_t;

  vec_t vecs [NPTS];
  res_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_pass(input int i, input int o);
    return (o > vecs[i].thr) || (o == vecs[i].late);
  endfunction

  function automatic int exp_rd(input int a);
    if (a >= NPTS) return 0;
`ifdef SETUP_MONOTONIC_CHECK_EN
    return (vecs[a].nm << (OFFW + 1)) | (vecs[a].found << OFFW) | vecs[a].code;
`else
    return (vecs[a].found << OFFW) | vecs[a].code;
`endif
  endfunction

  task automatic send_trial(input int o, input bit pass);
    bit e;
    e            = 1'($urandom_range(0, 1));
    trial_valid  = 1'b1;
    trial_offset = OFFW'(o);
    trial_exp    = e;
    trial_q      = pass ? e : ~e;
    tick();
    trial_valid  = 1'b0;
  endtask

  task automatic wait_rv(input logic val, input string name);
    int n = 0;
    while (res_valid !== val && n < 30) begin
      tick();
      n++;
    end
    chk(name, int'(res_valid), int'(val));
  endtask

  task automatic run_point(input int i);
    res_t r;
    int   fexp;
    r.ck = i / 3; r.d = i % 3; r.code = vecs[i].code; r.found = vecs[i].found;
    sb.push_back(r);
    if (i == 0) res_ready = 1'b0;
    for (int o = 100; o >= 0; o--) begin
      if (i == 5 && o == 58) begin
        chk("err_before", int'(err), 0);
        send_trial(57, 1'b1);
        chk("err_out_of_seq", int'(err), 1);
      end
      if (i == 1 && o == 60) start = 1'b1;
      send_trial(o, is_pass(i, o));
      start = 1'b0;
    end
    chk("res_valid_lat", int'(res_valid), 1);
    if (i == 0) begin
      fexp = (r.ck << 10) | (r.d << 8) | (r.found << 7) | r.code;
      for (int k = 0; k < 10; k++) begin
        if (k == 3) begin
          trial_valid = 1'b1; trial_offset = '0; trial_exp = 1'b1; trial_q = 1'b0;
        end
        tick();
        trial_valid = 1'b0;
        chk("hold_valid", int'(res_valid), 1);
        chk("hold_fields", (int'(res_ck_idx) << 10) | (int'(res_d_idx) << 8) |
            (int'(res_found) << 7) | int'(res_code), fexp);
      end
      chk("err_commit_trial", int'(err), 0);
      res_ready = 1'b1;
    end
    wait_rv(1'b0, "handshake");
  endtask

  // Scoreboard: pop and compare on each valid/ready handshake
  always @(negedge clk) begin
    res_t r;
    if (!rst && res_valid && res_ready) begin
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("res_ck_idx", int'(res_ck_idx), r.ck);
        chk("res_d_idx", int'(res_d_idx), r.d);
        chk("res_code", int'(res_code), r.code);
        chk("res_found", int'(res_found), r.found);
      end
    end
  end

  // Watchdog against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{22,  -1, 23,  1, 0};
    vecs[1] = '{100, -1, 127, 0, 0};
    vecs[2] = '{22,  10, 23,  1, 1};
    vecs[3] = '{-1,  -1, 0,   1, 0};
    vecs[4] = '{22,  -1, 23,  1, 0};
    vecs[5] = '{22,  -1, 23,  1, 0};
    vecs[6] = '{40,  -1, 41,  1, 0};
    vecs[7] = '{22,  -1, 23,  1, 0};
    vecs[8] = '{0,   -1, 1,   1, 0};

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_code", int'(res_code), 127);
    chk("rst_res_found", int'(res_found), 0);
    chk("rst_idx", (int'(res_ck_idx) << 2) | int'(res_d_idx), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst = 1'b0;

    // trial in IDLE is ignored
    trial_valid = 1'b1; trial_offset = OFFW'(5); trial_exp = 1'b1; trial_q = 1'b1;
    tick();
    trial_valid = 1'b0;
    chk("idle_trial_err", int'(err), 0);
    chk("idle_trial_busy", int'(busy), 0);

    // start together with a failing offset-100 trial: start wins, trial dropped
    start = 1'b1; trial_valid = 1'b1; trial_offset = OFFW'(100); trial_exp = 1'b1; trial_q = 1'b0;
    tick();
    start = 1'b0; trial_valid = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);

    // campaign 1: all points from the vector table
    for (int i = 0; i < NPTS; i++) begin
      run_point(i);
`ifdef SETUP_MONOTONIC_CHECK_EN
      if (i == 1) chk("nonmono_clear", int'(nonmono), 0);
      if (i == 2) chk("nonmono_set", int'(nonmono), 1);
`endif
    end
    chk("camp_done", int'(done), 1);
    chk("camp_busy", int'(busy), 0);
    chk("camp_err_sticky", int'(err), 1);

    // table dump, including out-of-range addresses
    for (int a = 0; a <= NPTS; a++) begin
      rd_addr = 4'(a);
      tick();
      chk($sformatf("rd_addr_%0d", a), int'(rd_data), exp_rd(a));
    end
    rd_addr = 4'd15;
    tick();
    chk("rd_addr_15", int'(rd_data), 0);

    // campaign 2: reset in the middle of point (1,2)
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_err", int'(err), 0);
    chk("restart_done", int'(done), 0);
    for (int i = 0; i < 5; i++) run_point(i);
    for (int o = 100; o >= 50; o--) send_trial(o, is_pass(5, o));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_res_valid", int'(res_valid), 0);
    chk("midrst_done", int'(done), 0);
`ifdef SETUP_MONOTONIC_CHECK_EN
    chk("midrst_nonmono", int'(nonmono), 0);
`endif
    for (int a = 0; a < NPTS; a++) begin
      rd_addr = 4'(a);
      tick();
      chk($sformatf("midrst_found_%0d", a), int'(rd_data[OFFW]), 0);
    end

    // campaign 3: restart begins again at (0,0)
    start = 1'b1;
    tick();
    start = 1'b0;
    run_point(0);
    tick(); tick();
    chk("sb_drained", int'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
